ldpc_err_cnt: RTL
=================

LDPC_ERR_CNT -- requirements
Module: ldpc_err_cnt

Interface
REQ-001 Parameter DIM, default 2304; decoded codeword width in bits, equal to R*D of the decoder.
REQ-002 Parameter SEG, default 64; bits counted per clock; DIM SHALL be an integer multiple of SEG.
REQ-003 Parameter ERR_W, default 12; frame error count width; DIM SHALL be at most 2^ERR_W-1.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 term  input  1  decoder-finished level from ldpc_core; a 0->1 transition marks a new frame.
REQ-007 res  input  DIM  hard-decision decoded bits; valid while term=1.
REQ-008 clear  input  1  synchronous clear of the running totals.
REQ-009 errs  output  ERR_W  bit-error count of the last completed frame.
REQ-010 frame_err  output  1  last completed frame had errs>0.
REQ-011 done  output  1  single-cycle pulse when errs/totals update.
REQ-012 busy  output  1  high while a frame is being counted.
REQ-013 overrun  output  1  sticky: a frame start was dropped while busy.
REQ-014 tot_frames  output  32  frames counted since reset/clear.
REQ-015 tot_ferr  output  32  frames with frame_err=1 since reset/clear.
REQ-016 tot_berr  output  48  bit errors accumulated since reset/clear.

Function
REQ-017 Transmitted codeword SHALL be all-zero; every res bit equal to 1 SHALL count as one bit error.
REQ-018 term SHALL be registered (term_q); start SHALL be term & ~term_q.
REQ-019 FSM states SHALL be IDLE, COUNT, DONE; NSEG = DIM/SEG.
REQ-020 IDLE with start: res SHALL be latched into a DIM-bit shadow register, the segment index and accumulator SHALL be zeroed, and the FSM SHALL go to COUNT.
REQ-021 COUNT: each cycle, popcount of shadow[idx*SEG +: SEG] SHALL be added to the accumulator and idx SHALL increment; after idx = NSEG-1 the FSM SHALL go to DONE.
REQ-022 DONE (one cycle): errs SHALL load the accumulator.
REQ-023 DONE: frame_err SHALL load (accumulator != 0).
REQ-024 DONE: done SHALL be 1.
REQ-025 DONE: tot_frames SHALL increment by 1, tot_ferr SHALL increment by frame_err, and tot_berr SHALL add the accumulator.
REQ-026 DONE: the FSM SHALL return to IDLE.
REQ-027 Latency: done SHALL be high in the cycle NSEG+1 clock edges after the edge that samples start (37 for the defaults); the next start SHALL be accepted in the cycle after done.
REQ-028 busy SHALL be 1 in COUNT and DONE, and 0 in IDLE.
REQ-029 A start seen in COUNT or DONE SHALL be ignored and SHALL set overrun; the frame in progress SHALL be unaffected.
REQ-030 Changes on res after capture SHALL NOT affect the count.
REQ-031 term held high SHALL produce exactly one count; term low SHALL be don't-care for res.
REQ-032 The totals SHALL saturate at all-ones and SHALL NOT wrap.
REQ-033 errs SHALL NOT saturate, per REQ-003.
REQ-034 clear SHALL zero tot_frames, tot_ferr, tot_berr and overrun.
REQ-035 clear SHALL NOT affect the FSM, errs or frame_err.
REQ-036 clear coincident with DONE: the totals SHALL read 0 afterwards (clear wins), while errs and frame_err SHALL still update.
REQ-037 Start coincident with clear in IDLE SHALL be accepted normally.

Reset
REQ-038 rstn=0 SHALL immediately force: FSM=IDLE, term_q=0, idx=0, accumulator=0.
REQ-039 rstn=0 SHALL immediately zero all outputs, errs through tot_berr.
REQ-040 A reset during COUNT SHALL abandon the frame with no done pulse and no total update.
REQ-041 After rstn deasserts with term already 1, the first edge SHALL count as a start (term_q=0).

Verification
REQ-042 res=all-zero, term 0->1 -> done after 37 cycles; errs=0, frame_err=0, tot_frames=1, tot_ferr=0.
REQ-043 res=all-ones -> errs=2304, frame_err=1, tot_berr=2304; repeat once -> tot_berr=4608, tot_ferr=2.
REQ-044 Single 1 at bit 0, then a frame with a single 1 at bit 2303 -> errs=1 for each (first and last segment); tot_berr=2.
REQ-045 term held high 200 cycles -> exactly one done. Second term 0->1 10 cycles after start -> overrun=1, tot_frames=1; then clear -> overrun=0, totals 0.
REQ-046 rstn pulsed low mid-COUNT -> all outputs 0, no done. clear asserted in the DONE cycle -> totals 0, errs holds the new value.
REQ-047 Random res over 1000 frames -> errs and totals match a reference popcount model exactly.

Source files
------------

// File: rtl/ldpc_err_cnt_if.sv
// Bus between the LDPC decoder side and the bit-error counter: frame handshake in,
// per-frame result and running totals out.
interface ldpc_err_cnt_if #(
  parameter int DIM   = 2304,
  parameter int ERR_W = 12
);
  logic             term;
  logic [DIM-1:0]   res;
  logic             clear;
  logic [ERR_W-1:0] errs;
  logic             frame_err;
  logic             done;
  logic             busy;
  logic             overrun;
  logic [31:0]      tot_frames;
  logic [31:0]      tot_ferr;
  logic [47:0]      tot_berr;

  modport master (
    output term, res, clear,
    input  errs, frame_err, done, busy, overrun, tot_frames, tot_ferr, tot_berr
  );

  modport slave (
    input  term, res, clear,
    output errs, frame_err, done, busy, overrun, tot_frames, tot_ferr, tot_berr
  );
endinterface

// File: rtl/ldpc_err_cnt.sv
// Counts 1-bits (errors against an all-zero codeword) of each decoded frame, SEG bits
// per clock from a captured shadow copy, and keeps saturating running totals.
module ldpc_err_cnt #(
  parameter int DIM   = 2304,
  parameter int SEG   = 64,
  parameter int ERR_W = 12
) (
  input logic             clk,
  input logic             rstn,
  ldpc_err_cnt_if.slave   bus
);

  localparam int NSEG  = DIM / SEG;
  localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;

  state_e           state_q, state_d;
  logic             term_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ERR_W-1:0] acc_q, acc_d;
  logic [ERR_W-1:0] errs_q, errs_d;
  logic             ferr_q, ferr_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic [31:0]      tfr_q, tfr_d;
  logic [31:0]      tfe_q, tfe_d;
  logic [47:0]      tbe_q, tbe_d;
  logic [DIM-1:0]   shadow_q;
  logic             load;
  logic             start;
  logic [SEG-1:0]   seg_bits;
  logic [ERR_W-1:0] seg_cnt;
  logic [48:0]      berr_sum;

  function automatic logic [ERR_W-1:0] popcnt(input logic [SEG-1:0] v);
    logic [ERR_W-1:0] c;
    c = '0;
    for (int i = 0; i < SEG; i++) c = c + ERR_W'(v[i]);
    return c;
  endfunction

  assign start    = bus.term & ~term_q;
  assign seg_bits = shadow_q[int'(idx_q)*SEG +: SEG];
  assign seg_cnt  = popcnt(seg_bits);
  assign berr_sum = {1'b0, tbe_q} + 49'(acc_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    errs_d  = errs_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    tfr_d   = tfr_q;
    tfe_d   = tfe_q;
    tbe_d   = tbe_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          idx_d   = '0;
          acc_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (start) ovr_d = 1'b1;
        acc_d = acc_q + seg_cnt;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NSEG - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) ovr_d = 1'b1;
        errs_d  = acc_q;
        ferr_d  = (acc_q != '0);
        done_d  = 1'b1;
        tfr_d   = (tfr_q == '1) ? tfr_q : tfr_q + 32'd1;
        tfe_d   = ((acc_q != '0) && (tfe_q != '1)) ? tfe_q + 32'd1 : tfe_q;
        tbe_d   = berr_sum[48] ? '1 : berr_sum[47:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // clear only touches the totals and the sticky flag, and wins over a DONE update
    if (bus.clear) begin
      ovr_d = 1'b0;
      tfr_d = '0;
      tfe_d = '0;
      tbe_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      term_q  <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      errs_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      tfr_q   <= '0;
      tfe_q   <= '0;
      tbe_q   <= '0;
    end else begin
      state_q <= state_d;
      term_q  <= bus.term;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      errs_q  <= errs_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      tfr_q   <= tfr_d;
      tfe_q   <= tfe_d;
      tbe_q   <= tbe_d;
    end
  end

  // The shadow copy is always rewritten before use, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) shadow_q <= bus.res;
  end

  assign bus.errs       = errs_q;
  assign bus.frame_err  = ferr_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.overrun    = ovr_q;
  assign bus.tot_frames = tfr_q;
  assign bus.tot_ferr   = tfe_q;
  assign bus.tot_berr   = tbe_q;

endmodule
